// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Frame-granular round-robin arbiter in front of a single uart_tx byte
// transmitter. One requester owns the link for a whole frame: it feeds bytes
// over a valid/ack handshake and the link is only handed on after the byte
// flagged as last has been transmitted. Frames from different producers
// therefore never interleave on the serial line.
//
// Parameters
//   NUM_REQ         number of requesters, 2..4
//   TIMEOUT_CYCLES  idle cycles a granted owner may leave byte_valid low
//                   before the grant is revoked (>= 1, watchdog build only)
//
// Optional feature
//   ARB_TIMEOUT_EN  when defined, builds the stalled-owner watchdog; when not
//                   defined a stalled owner keeps the link and timeout_flag
//                   is tied low.
//
// Ports
//   clk_12MHz     in   system clock
//   rstn          in   asynchronous active-low reset
//   req           in   [NUM_REQ]    requester i wants to send one frame
//   byte_valid    in   [NUM_REQ]    requester i presents a byte
//   byte_last     in   [NUM_REQ]    presented byte ends the frame
//   byte_data     in   [8*NUM_REQ]  byte of requester i in [8i+7:8i]
//   byte_ack      out  [NUM_REQ]    one-cycle pulse: byte of i consumed
//   grant         out  [NUM_REQ]    one-hot link owner, 0 when idle
//   uart_start    out  one-cycle start pulse to uart_tx
//   uart_data     out  [8] byte to uart_tx, held until uart_ready returns
//   uart_ready    in   uart_tx is idle
//   busy          out  high in every state except IDLE
//   timeout_flag  out  one-cycle pulse when the watchdog revokes a grant
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                 clk_12MHz,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   byte_valid,
  input  logic [NUM_REQ-1:0]   byte_last,
  input  logic [8*NUM_REQ-1:0] byte_data,
  output logic [NUM_REQ-1:0]   byte_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  input  logic                 uart_ready,
  output logic                 busy,
  output logic                 timeout_flag
);

  localparam int OWNER_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Illegal parameter values elaborate a visibly named, empty scope so they
  // show up in the hierarchy of any netlist or simulation that uses them.
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_illegal_num_req
  end
  if (TIMEOUT_CYCLES < 1) begin : g_illegal_timeout_cycles
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_WAIT_BUSY,
    S_WAIT_READY,
    S_RELEASE
  } state_e;

  state_e               state_q,      state_d;
  logic [OWNER_W-1:0]   owner_q,      owner_d;
  logic [OWNER_W-1:0]   last_owner_q, last_owner_d;
  logic [NUM_REQ-1:0]   grant_q,      grant_d;
  logic [NUM_REQ-1:0]   byte_ack_q,   byte_ack_d;
  logic                 uart_start_q, uart_start_d;
  logic [7:0]           uart_data_q,  uart_data_d;
  logic                 last_flag_q,  last_flag_d;

  // Signals of the current owner, selected by owner index.
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;

  // Round-robin pick for the next grant.
  logic [2*NUM_REQ-1:0] req_rot_wide;
  logic [NUM_REQ-1:0]   req_rot;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_found;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]     idle_cnt_q,   idle_cnt_d;
  logic                 timeout_q,    timeout_d;
`endif

  // ---------------------------------------------------------------------------
  // Owner-side input mux
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == OWNER_W'(i)) begin
        sel_valid = byte_valid[i];
        sel_last  = byte_last[i];
        sel_data  = byte_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search starting at last_owner+1. The request vector is
  // doubled and shifted so bit 0 of req_rot is the first candidate; the
  // candidate index is then unrotated with a single conditional subtract.
  // ---------------------------------------------------------------------------
  always_comb begin
    int cand;
    req_rot_wide = {req, req} >> (int'(last_owner_q) + 1);
    req_rot      = req_rot_wide[NUM_REQ-1:0];
    pick_found   = 1'b0;
    pick_idx     = '0;
    cand         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        cand       = int'(last_owner_q) + 1 + k;
        if (cand >= NUM_REQ) begin
          cand = cand - NUM_REQ;
        end
        pick_idx   = OWNER_W'(cand);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that left one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    byte_ack_d   = '0;
    uart_start_d = 1'b0;
    uart_data_d  = uart_data_q;
    last_flag_d  = last_flag_q;
`ifdef ARB_TIMEOUT_EN
    idle_cnt_d   = '0;
    timeout_d    = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
          state_d = S_WAIT_BYTE;
        end
      end

      S_WAIT_BYTE: begin
`ifdef ARB_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
`endif
        if (sel_valid && uart_ready) begin
          uart_data_d  = sel_data;
          last_flag_d  = sel_last;
          uart_start_d = 1'b1;
          byte_ack_d   = grant_q;
          state_d      = S_WAIT_BUSY;
`ifdef ARB_TIMEOUT_EN
          idle_cnt_d   = '0;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        else if (!sel_valid) begin
          // Counter holds while a byte waits on uart_ready; it only advances
          // while the owner has nothing to offer.
          if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            grant_d    = '0;
            timeout_d  = 1'b1;
            state_d    = S_RELEASE;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
`endif
      end

      // uart_tx needs one cycle to drop ready after the start pulse, so
      // ready is not looked at here.
      S_WAIT_BUSY: begin
        state_d = S_WAIT_READY;
      end

      S_WAIT_READY: begin
        if (uart_ready) begin
          if (last_flag_q) begin
            // Dropping grant on the way into RELEASE gives the two-cycle
            // grant-low gap between frames (RELEASE plus IDLE).
            grant_d = '0;
            state_d = S_RELEASE;
          end else begin
            state_d = S_WAIT_BYTE;
          end
        end
      end

      S_RELEASE: begin
        grant_d      = '0;
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end

      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      last_owner_q <= OWNER_W'(NUM_REQ - 1);
      grant_q      <= '0;
      byte_ack_q   <= '0;
      uart_start_q <= 1'b0;
      uart_data_q  <= 8'h00;
      last_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      byte_ack_q   <= byte_ack_d;
      uart_start_q <= uart_start_d;
      uart_data_q  <= uart_data_d;
      last_flag_q  <= last_flag_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk_12MHz or negedge rstn) begin
    if (!rstn) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant      = grant_q;
  assign byte_ack   = byte_ack_q;
  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with three requesters. Each requester is
// a byte queue ({last, data}); it raises req while its queue is non-empty and
// pops a byte the cycle after it sees byte_ack. A small uart_tx model drops
// ready one cycle after each start pulse and keeps it low for BUSY_CYC cycles.
// Expected byte orders and grant sequences are written out by hand.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N        = 3;
  localparam int BUSY_CYC = 10;

  logic           clk_12MHz = 1'b0;
  logic           rstn      = 1'b0;
  logic [N-1:0]   req        = '0;
  logic [N-1:0]   byte_valid = '0;
  logic [N-1:0]   byte_last  = '0;
  logic [8*N-1:0] byte_data  = '0;
  logic [N-1:0]   byte_ack;
  logic [N-1:0]   grant;
  logic           uart_start;
  logic [7:0]     uart_data;
  logic           uart_ready;
  logic           busy;
  logic           timeout_flag;

  logic           model_ready = 1'b1;
  logic           hold_low    = 1'b0;

  assign uart_ready = model_ready & ~hold_low;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk_12MHz    (clk_12MHz),
    .rstn         (rstn),
    .req          (req),
    .byte_valid   (byte_valid),
    .byte_last    (byte_last),
    .byte_data    (byte_data),
    .byte_ack     (byte_ack),
    .grant        (grant),
    .uart_start   (uart_start),
    .uart_data    (uart_data),
    .uart_ready   (uart_ready),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  initial forever #5 clk_12MHz = ~clk_12MHz;

  // Requester queues and observation logs.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [7:0] tx_log[$];
  logic [2:0] grant_log[$];

  int         n_vec = 0;
  int         n_err = 0;
  int         start_cnt = 0;
  int         ack_cnt0 = 0;
  int         ack_cnt_other = 0;
  int         busy_cnt = 0;
  int         zero_run = 0;
  int         min_gap = 1000;
  bit         seen_grant = 0;
  bit         tf_seen = 0;
  logic       start_prev = 1'b0;
  logic [2:0] ack_prev = '0;
  logic [2:0] grant_prev = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_tx(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 'x;
  endfunction

  function automatic logic [2:0] get_gl(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 'x;
  endfunction

  task automatic drive_reqs();
    byte_valid = '0;
    byte_last  = '0;
    byte_data  = '0;
    if (q0.size() != 0) begin
      byte_valid[0] = 1'b1; byte_last[0] = q0[0][8]; byte_data[7:0] = q0[0][7:0];
    end
    if (q1.size() != 0) begin
      byte_valid[1] = 1'b1; byte_last[1] = q1[0][8]; byte_data[15:8] = q1[0][7:0];
    end
    if (q2.size() != 0) begin
      byte_valid[2] = 1'b1; byte_last[2] = q2[0][8]; byte_data[23:16] = q2[0][7:0];
    end
    req = byte_valid;
  endtask

  // Producer, uart_tx and monitor model, stepped 1 time unit after each edge.
  always begin
    @(posedge clk_12MHz);
    #1;
    if (!rstn) begin
      q0.delete(); q1.delete(); q2.delete();
      model_ready = 1'b1;
      busy_cnt    = 0;
      start_prev  = 1'b0;
      ack_prev    = '0;
      grant_prev  = '0;
      zero_run    = 0;
      seen_grant  = 0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_ready = 1'b1;
      end
      if (start_prev) begin
        model_ready = 1'b0;
        busy_cnt    = BUSY_CYC;
      end
      if (ack_prev[0] && q0.size() != 0) void'(q0.pop_front());
      if (ack_prev[1] && q1.size() != 0) void'(q1.pop_front());
      if (ack_prev[2] && q2.size() != 0) void'(q2.pop_front());
      start_prev = uart_start;
      ack_prev   = byte_ack;
      if (uart_start) begin
        tx_log.push_back(uart_data);
        start_cnt++;
      end
      if (byte_ack[0]) ack_cnt0++;
      if (byte_ack[1] || byte_ack[2]) ack_cnt_other++;
      if (timeout_flag) tf_seen = 1;
      if (grant != 0 && grant != grant_prev) grant_log.push_back(grant);
      if (grant != 0 && grant_prev == 0 && seen_grant && zero_run < min_gap)
        min_gap = zero_run;
      if (grant == 0) zero_run++;
      else begin
        zero_run   = 0;
        seen_grant = 1;
      end
      grant_prev = grant;
    end
    drive_reqs();
  end

  task automatic clear_logs();
    tx_log.delete();
    grant_log.delete();
    start_cnt     = 0;
    ack_cnt0      = 0;
    ack_cnt_other = 0;
    min_gap       = 1000;
    tf_seen       = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk_12MHz);
    rstn = 1'b1;
    @(negedge clk_12MHz);
    clear_logs();
  endtask

  // Wait until n bytes were started (and, if need_idle, the arbiter is idle).
  task automatic wait_tx(input int n, input bit need_idle, input int budget,
                         input string tag);
    int k = 0;
    while ((tx_log.size() < n || (need_idle && busy)) && k < budget) begin
      @(negedge clk_12MHz);
      k++;
    end
    check({tag, "_in_time"}, 32'(k < budget), 32'd1);
  endtask

  initial begin
    // ---- Reset values ----
    repeat (2) @(negedge clk_12MHz);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack", 32'(byte_ack), 32'h0);
    check("rst_start", 32'(uart_start), 32'h0);
    check("rst_data", 32'(uart_data), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tflag", 32'(timeout_flag), 32'h0);
    rstn = 1'b1;
    @(negedge clk_12MHz);
    clear_logs();

    // ---- Single requester, 3-byte frame ----
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b0, 8'hA2});
    q0.push_back({1'b1, 8'hA3});
    @(negedge clk_12MHz);
    check("t1_req_seen", 32'(req), 32'h1);
    check("t1_grant_before", 32'(grant), 32'h0);
    @(negedge clk_12MHz);
    check("t1_grant_latency", 32'(grant), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    @(negedge clk_12MHz);
    check("t1_first_start", 32'(uart_start), 32'h1);
    check("t1_first_data", 32'(uart_data), 32'hA1);
    check("t1_first_ack", 32'(byte_ack), 32'h1);
    wait_tx(3, 1'b1, 300, "t1");
    check("t1_bytes", {8'h00, get_tx(0), get_tx(1), get_tx(2)}, 32'h00A1A2A3);
    check("t1_start_cnt", 32'(start_cnt), 32'd3);
    check("t1_ack0_cnt", 32'(ack_cnt0), 32'd3);
    check("t1_ack_other", 32'(ack_cnt_other), 32'd0);
    check("t1_grant_runs", 32'(grant_log.size()), 32'd1);
    check("t1_grant_owner", 32'(get_gl(0)), 32'h1);
    check("t1_grant_end", 32'(grant), 32'h0);

    // ---- Round robin over three 1-byte producers ----
    do_reset();
    q0.push_back({1'b1, 8'h10});
    q0.push_back({1'b1, 8'h10});
    q1.push_back({1'b1, 8'h20});
    q2.push_back({1'b1, 8'h30});
    wait_tx(4, 1'b1, 400, "t2");
    check("t2_bytes", {get_tx(0), get_tx(1), get_tx(2), get_tx(3)}, 32'h10203010);
    check("t2_grants", {20'h0, get_gl(0), get_gl(1), get_gl(2), get_gl(3)},
          32'b001_010_100_001);
    check("t2_grant_runs", 32'(grant_log.size()), 32'd4);
    check("t2_frame_gap", 32'(min_gap), 32'd2);

    // ---- No interleave: requester 1 asks mid-frame ----
    do_reset();
    q0.push_back({1'b0, 8'hC0});
    q0.push_back({1'b0, 8'hC1});
    q0.push_back({1'b0, 8'hC2});
    q0.push_back({1'b1, 8'hC3});
    wait_tx(2, 1'b0, 200, "t3_mid");
    q1.push_back({1'b1, 8'hD0});
    wait_tx(5, 1'b1, 400, "t3");
    check("t3_bytes_r0", {get_tx(0), get_tx(1), get_tx(2), get_tx(3)}, 32'hC0C1C2C3);
    check("t3_byte_r1", 32'(get_tx(4)), 32'hD0);
    check("t3_grants", {26'h0, get_gl(0), get_gl(1)}, 32'b001_010);

    // ---- Ready gating ----
    do_reset();
    hold_low = 1'b1;
    q0.push_back({1'b1, 8'h55});
    repeat (50) @(negedge clk_12MHz);
    check("t4_no_start", 32'(start_cnt), 32'd0);
    check("t4_no_ack", 32'(ack_cnt0), 32'd0);
    check("t4_grant_held", 32'(grant), 32'h1);
    check("t4_start_low", 32'(uart_start), 32'h0);
    hold_low = 1'b0;
    @(negedge clk_12MHz);
    check("t4_start_after", 32'(uart_start), 32'h1);
    check("t4_data_after", 32'(uart_data), 32'h55);
    check("t4_ack_after", 32'(byte_ack), 32'h1);
    wait_tx(1, 1'b1, 200, "t4");

    // ---- Reset asserted in WAIT_READY ----
    do_reset();
    q0.push_back({1'b0, 8'hB1});
    q0.push_back({1'b0, 8'hB2});
    q0.push_back({1'b1, 8'hB3});
    wait_tx(1, 1'b0, 200, "t5_first");
    repeat (4) @(negedge clk_12MHz);
    check("t5_busy_pre", 32'(busy), 32'h1);
    check("t5_data_pre", 32'(uart_data), 32'hB1);
    #2;
    rstn = 1'b0;
    #1;
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_data", 32'(uart_data), 32'h00);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_ack_start", {30'h0, uart_start, timeout_flag}, 32'h0);
    check("t5_rst_ack", 32'(byte_ack), 32'h0);
    repeat (2) @(negedge clk_12MHz);
    rstn = 1'b1;
    @(negedge clk_12MHz);
    clear_logs();
    q1.push_back({1'b1, 8'h77});
    q0.push_back({1'b1, 8'h66});
    wait_tx(2, 1'b1, 300, "t5");
    check("t5_bytes", {16'h0, get_tx(0), get_tx(1)}, 32'h6677);
    check("t5_first_owner", 32'(get_gl(0)), 32'h1);

    // ---- Stalled owner ----
    do_reset();
    q0.push_back({1'b0, 8'h81});
    wait_tx(1, 1'b0, 200, "t6_first");
    q1.push_back({1'b1, 8'h91});
    repeat (60) @(negedge clk_12MHz);
`ifdef ARB_TIMEOUT_EN
    wait_tx(2, 1'b1, 300, "t6");
    check("t6_tflag_seen", 32'(tf_seen), 32'h1);
    check("t6_next_byte", 32'(get_tx(1)), 32'h91);
    check("t6_next_owner", 32'(get_gl(1)), 32'h2);
`else
    check("t6_grant_held", 32'(grant), 32'h1);
    check("t6_busy_held", 32'(busy), 32'h1);
    check("t6_no_tflag", 32'(tf_seen), 32'h0);
    check("t6_one_byte", 32'(start_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-granular round-robin arbiter that shares the single `uart_tx` byte transmitter between `NUM_REQ` frame producers, for example the sensor-frame serial transmitter and a status/heartbeat producer. A requester is granted the link for a whole frame. It feeds bytes over a valid/ack handshake until it flags the last byte. Only then does the link move on, so frames from different sources never interleave on `tx`. It sits between the producers and the `uart_tx` instance.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, legal range 2..4.
- `TIMEOUT_CYCLES`, default 12000: cycles a granted requester may leave `byte_valid` low before the grant is revoked. Used only with `ARB_TIMEOUT_EN`. Must be ≥1.

Ports:
- `clk_12MHz`, in, 1: the single system clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `req`, in, NUM_REQ: requester i asks for the link to send one frame.
- `byte_valid`, in, NUM_REQ: requester i presents a byte.
- `byte_last`, in, NUM_REQ: the presented byte is the last of the frame.
- `byte_data`, in, 8*NUM_REQ: byte of requester i in bits [8i+7:8i].
- `byte_ack`, out, NUM_REQ: one-cycle pulse when the byte of requester i is consumed.
- `grant`, out, NUM_REQ: one-hot owner of the link, or 0 when idle.
- `uart_start`, out, 1: one-cycle start pulse to `uart_tx`.
- `uart_data`, out, 8: byte to `uart_tx`, stable from the start pulse until `uart_ready` returns.
- `uart_ready`, in, 1: `uart_tx` is idle.
- `busy`, out, 1: high in every state except IDLE.
- `timeout_flag`, out, 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- Reset values: `grant`=0, `byte_ack`=0, `uart_start`=0, `uart_data`=8'h00, `busy`=0, `timeout_flag`=0.
- Reset state: FSM in IDLE and round-robin pointer `last_owner`=NUM_REQ-1, so requester 0 wins first after reset.
- Reset asserted mid-frame clears everything at once. The byte already inside `uart_tx` is not this block's concern.
- IDLE: if `req`≠0, grant the first set bit searching from `last_owner`+1 with wrap-around, then go to WAIT_BYTE. Otherwise stay in IDLE.
- WAIT_BYTE: if `byte_valid[g]` and `uart_ready` are both high:
  - latch `byte_data[g]` into `uart_data` and latch `byte_last[g]`;
  - pulse `uart_start` and `byte_ack[g]`;
  - go to WAIT_BUSY.
- WAIT_BUSY: deassert the pulses and ignore `uart_ready` for this one cycle, which covers the `uart_tx` ready-drop latency. Go to WAIT_READY.
- WAIT_READY: when `uart_ready`=1, go to RELEASE if the latched last flag is set, otherwise go back to WAIT_BYTE.
- RELEASE: `grant`←0, `last_owner`←g, go to IDLE.
- `req`, `byte_valid` and `byte_last` of non-granted requesters are ignored.
- Deassertion of `req[g]` mid-frame is ignored; only `byte_last` ends a frame.
- A frame of exactly one byte is legal: `byte_last` is set on its first byte.

## Timing
- Grant latency: `req` sampled high in IDLE at edge N gives `grant` high after edge N.
- First byte: the first `uart_start`/`byte_ack` can occur at edge N+1 at the earliest.
- Per-byte overhead: 2 cycles (WAIT_BUSY plus the minimum of one WAIT_READY cycle) on top of the `uart_tx` busy time.
- Frame gap: RELEASE plus IDLE give at least 2 cycles of `grant`=0 between consecutive frames, even with the same requester.
- Byte handshake: the requester holds `byte_valid`, `byte_data` and `byte_last` until it sees `byte_ack`. It may change them in the cycle after the ack.
- Simultaneous requests in IDLE are resolved in one cycle by the round-robin pointer. No requester waits more than NUM_REQ-1 frames.

## Configuration
- Macro `ARB_TIMEOUT_EN`, when defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT_BYTE while `byte_valid[g]`=0. It is cleared on entry to WAIT_BYTE and whenever a byte is accepted.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to RELEASE and `timeout_flag` pulses for 1 cycle.
  - `last_owner` is updated as for a normal release.
- Macro not defined: no counter is built, a stalled owner holds the link indefinitely, and `timeout_flag` is tied to 0.

## Test plan
- Single requester: reset, `req[0]`=1, 3-byte frame 8'hA1, 8'hA2, 8'hA3 with last on A3, and `uart_ready` dropping 1 cycle after each start for 10 cycles.
  - Expect exactly 3 `uart_start` pulses with `uart_data` A1, A2, A3 and 3 `byte_ack[0]` pulses.
  - Expect `grant`=3'b001 throughout, then 0.
- Round-robin: `req`=3'b111 held, each requester sends 1-byte frames 8'h10, 8'h20, 8'h30.
  - Expect grant order 001, 010, 100, 001 and `tx` byte order 10, 20, 30, 10.
- No interleave: requester 1 asserts `req` mid-way through a 4-byte frame from requester 0.
  - Expect all 4 bytes of requester 0 sent contiguously before `grant`=010.
- Ready gating: hold `uart_ready`=0 for 50 cycles while `byte_valid[g]`=1.
  - Expect no `uart_start` and no `byte_ack` until the cycle after `uart_ready` rises.
- Reset mid-frame: assert `rstn`=0 during WAIT_READY.
  - Expect all outputs at their reset values immediately, without a clock edge.
  - Expect requester 0 to win the next grant.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20): the owner sends 1 byte without last, then holds `byte_valid` low.
  - Expect `timeout_flag` to pulse and `grant` to drop 20 cycles after entry to WAIT_BYTE.
  - Expect the next pending requester to be granted.
  - Without the macro, expect `grant` to be held indefinitely and `timeout_flag`=0.
